// File: rtl/phased_clock_array.sv
`default_nettype none
// ============================================================================
// Module   : phased_clock_array
// Purpose  : Multi-channel square-wave generator driven by one shared period
//            counter. Each channel has its own phase offset. The host writes
//            phase values into shadow registers, and an update strobe commits
//            every shadow to the active set on a period boundary. A new
//            pattern therefore never produces a glitched or partial period.
// Ports    : clk      - system clock
//            rst      - synchronous reset, active-low
//            en       - run enable; low holds the counter at 0 and forces
//                       the outputs low
//            wr_en    - shadow register write strobe
//            wr_addr  - channel index of the write
//            wr_data  - phase offset in cycles (duty when wr_duty=1)
//            wr_duty  - selects the duty shadow (ARRAY_DUTY_EN only)
//            update   - requests a commit of shadow to active
//            out      - transducer drive, bit i = channel i
//            sync     - one-cycle pulse marking the period start on out
//            pending  - a commit has been requested but not yet applied
//            wr_err   - one-cycle pulse after a rejected write
// Options  : ARRAY_DUTY_EN - adds per-channel programmable duty storage and
//            the wr_duty port. Without it, duty is fixed at floor(PERIOD/2).
// Revision : 1.0 - initial release
// ============================================================================
module phased_clock_array #(
    parameter int CHANNELS = 16,
    parameter int WIDTH    = 11,
    parameter int PERIOD   = 1250,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
`ifdef ARRAY_DUTY_EN
    input  logic                wr_duty,
`endif
    input  logic                update,
    output logic [CHANNELS-1:0] out,
    output logic                sync,
    output logic                pending,
    output logic                wr_err
);

    localparam logic [WIDTH-1:0] c_period_m1 = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH:0]   c_period_x  = (WIDTH+1)'(PERIOD);
    localparam logic [ADDR_W:0]  c_channels  = (ADDR_W+1)'(CHANNELS);

    logic [WIDTH-1:0]    r_cnt;
    logic [CHANNELS-1:0] r_out;
    logic                r_sync;
    logic                r_pending;
    logic                r_wr_err;
    logic [WIDTH-1:0]    r_shadow_phase [CHANNELS];
    logic [WIDTH-1:0]    r_active_phase [CHANNELS];

    logic                w_at_end;
    logic                w_commit;
    logic                w_addr_ok;
    logic                w_phase_ok;
    logic                w_wr_phase;
    logic                w_wr_reject;
    logic [CHANNELS-1:0] w_hit;

    assign w_at_end   = (r_cnt == c_period_m1);
    // A disabled array has no period boundary to wait for, so a pending
    // commit is applied immediately.
    assign w_commit   = r_pending && (w_at_end || !en);
    assign w_addr_ok  = ({1'b0, wr_addr} < c_channels);
    assign w_phase_ok = ({1'b0, wr_data} < c_period_x);

`ifdef ARRAY_DUTY_EN
    logic [WIDTH-1:0] r_shadow_duty [CHANNELS];
    logic [WIDTH-1:0] r_active_duty [CHANNELS];
    logic             w_duty_ok;
    logic             w_wr_duty;

    localparam logic [WIDTH-1:0] c_half = WIDTH'(PERIOD / 2);

    // Duty may equal PERIOD (constant high); phase must stay below it.
    assign w_duty_ok   = ({1'b0, wr_data} <= c_period_x);
    assign w_wr_phase  = wr_en && !wr_duty && w_addr_ok && w_phase_ok;
    assign w_wr_duty   = wr_en &&  wr_duty && w_addr_ok && w_duty_ok;
    assign w_wr_reject = wr_en && !(w_wr_phase || w_wr_duty);

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst) begin
                r_shadow_duty[i] <= c_half;
                r_active_duty[i] <= c_half;
            end else begin
                if (w_commit) begin
                    r_active_duty[i] <= r_shadow_duty[i];
                end
                if (w_wr_duty && (wr_addr == ADDR_W'(i))) begin
                    r_shadow_duty[i] <= wr_data;
                end
            end
        end
    end
`else
    localparam logic [WIDTH-1:0] c_half = WIDTH'(PERIOD / 2);

    assign w_wr_phase  = wr_en && w_addr_ok && w_phase_ok;
    assign w_wr_reject = wr_en && !w_wr_phase;
`endif

    // Per-channel position within the period. Both operands are below
    // PERIOD, so a single conditional subtraction gives the modulo result.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [WIDTH:0]   w_sum;
        logic [WIDTH:0]   w_pos;
        logic [WIDTH-1:0] w_duty;

        assign w_sum = {1'b0, r_cnt} + {1'b0, r_active_phase[gi]};
        assign w_pos = (w_sum >= c_period_x) ? (w_sum - c_period_x) : w_sum;
`ifdef ARRAY_DUTY_EN
        assign w_duty = r_active_duty[gi];
`else
        assign w_duty = c_half;
`endif
        assign w_hit[gi] = (w_pos < {1'b0, w_duty});
    end

    // Counter, drive outputs and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_out     <= '0;
            r_sync    <= 1'b0;
            r_pending <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            if (!en || w_at_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_out     <= en ? w_hit : '0;
            r_sync    <= en && (r_cnt == '0);
            r_wr_err  <= w_wr_reject;
            // A fresh request on the commit edge wins over the clear.
            r_pending <= update || (r_pending && !w_commit);
        end
    end

    // Phase storage. The commit copies the shadow contents from before this
    // edge, so a write landing on the commit edge waits for the next commit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst) begin
                r_shadow_phase[i] <= '0;
                r_active_phase[i] <= '0;
            end else begin
                if (w_commit) begin
                    r_active_phase[i] <= r_shadow_phase[i];
                end
                if (w_wr_phase && (wr_addr == ADDR_W'(i))) begin
                    r_shadow_phase[i] <= wr_data;
                end
            end
        end
    end

    assign out     = r_out;
    assign sync    = r_sync;
    assign pending = r_pending;
    assign wr_err  = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_phased_clock_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_phased_clock_array
// Purpose  : Self-checking bench for phased_clock_array at PERIOD=10,
//            CHANNELS=4. It uses a behavioural model that works from
//            modulo arithmetic on a cycle-level period position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phased_clock_array;

    localparam int P = 10;
    localparam int C = 4;
    localparam int W = 4;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         wr_en = 1'b0;
    logic         wr_duty = 1'b0;
    logic         update = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [C-1:0] out;
    logic         sync;
    logic         pending;
    logic         wr_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int           m_cnt = 0;
    int           m_sh_ph [C];
    int           m_ac_ph [C];
    int           m_sh_du [C];
    int           m_ac_du [C];
    logic [C-1:0] m_out  = '0;
    logic         m_sync = 1'b0;
    logic         m_pend = 1'b0;
    logic         m_err  = 1'b0;

    phased_clock_array #(
        .CHANNELS (C),
        .WIDTH    (W),
        .PERIOD   (P),
        .ADDR_W   (A)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef ARRAY_DUTY_EN
        .wr_duty (wr_duty),
`endif
        .update  (update),
        .out     (out),
        .sync    (sync),
        .pending (pending),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    // Advance one clock: predict from the pre-edge inputs, then wait for the
    // edge and settle 1 time unit past it.
    task automatic tick();
        logic [C-1:0] n_out;
        logic         n_sync;
        logic         n_pend;
        logic         n_err;
        bit           commit;
        bit           is_duty;
        bit           ok;
        int           n_cnt;
        int           lim;
        if (!rst) begin
            n_cnt  = 0;
            n_out  = '0;
            n_sync = 1'b0;
            n_pend = 1'b0;
            n_err  = 1'b0;
            for (int i = 0; i < C; i++) begin
                m_sh_ph[i] = 0;
                m_ac_ph[i] = 0;
                m_sh_du[i] = P / 2;
                m_ac_du[i] = P / 2;
            end
        end else begin
            n_cnt  = en ? (m_cnt + 1) % P : 0;
            for (int i = 0; i < C; i++)
                n_out[i] = en && (((m_cnt + m_ac_ph[i]) % P) < m_ac_du[i]);
            n_sync = en && (m_cnt == 0);
`ifdef ARRAY_DUTY_EN
            is_duty = wr_duty;
`else
            is_duty = 1'b0;
`endif
            lim    = is_duty ? P : P - 1;
            ok     = (int'(wr_addr) < C) && (int'(wr_data) <= lim);
            n_err  = wr_en && !ok;
            commit = m_pend && ((m_cnt == P - 1) || !en);
            if (commit) begin
                m_ac_ph = m_sh_ph;
                m_ac_du = m_sh_du;
            end
            if (wr_en && ok) begin
                if (is_duty) m_sh_du[wr_addr] = int'(wr_data);
                else         m_sh_ph[wr_addr] = int'(wr_data);
            end
            n_pend = update || (m_pend && !commit);
        end
        @(posedge clk);
        #1;
        m_cnt  = n_cnt;
        m_out  = n_out;
        m_sync = n_sync;
        m_pend = n_pend;
        m_err  = n_err;
    endtask

    task automatic write(input int addr, input int data, input bit duty);
        wr_en   = 1'b1;
        wr_addr = A'(addr);
        wr_data = W'(data);
        wr_duty = duty;
        tick();
        wr_en   = 1'b0;
        wr_duty = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 3 * P && m_cnt != target; i++) tick();
        n_checks++;
        if (m_cnt != target) $display("FAIL wait_cnt: cnt %0d, required %0d", m_cnt, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1;
        tick(); tick();
        n_checks++;
        if ({out, sync, pending, wr_err} !== '0)
            $display("FAIL reset: out=%b sync=%b pend=%b err=%b, required all 0", out, sync, pending, wr_err);
        else n_pass++;
    endtask

    task automatic test_free_run();
        int highs = 0;
        int syncs = 0;
        rst = 1'b1; en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (out[0]) highs++;
            if (sync) begin
                syncs++;
                n_checks++;
                if (out !== 4'hF) $display("FAIL free_run_sync_align: out=%b, required 1111", out);
                else n_pass++;
            end
            n_checks++;
            if ({out, sync, pending, wr_err} !== {m_out, m_sync, m_pend, m_err})
                $display("FAIL free_run: got %b, required %b", {out, sync, pending, wr_err}, {m_out, m_sync, m_pend, m_err});
            else n_pass++;
        end
        n_checks++;
        if (highs != 10 || syncs != 2) $display("FAIL free_run_counts: highs=%0d syncs=%0d, required 10 and 2", highs, syncs);
        else n_pass++;
    endtask

    task automatic test_phase_offset();
        int k;
        write(1, 3, 1'b0);
        update = 1'b1; tick(); update = 1'b0;
        k = 0;
        while (!sync && k < 3 * P) begin tick(); k++; end
        n_checks++;
        if (!sync || pending !== 1'b0) $display("FAIL phase_sync: sync=%b pend=%b, required 1 and 0", sync, pending);
        else n_pass++;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 6) begin
                n_checks++;
                if (out[1:0] !== 2'b00) $display("FAIL phase_k6: out[1:0]=%b, required 00", out[1:0]);
                else n_pass++;
            end
            if (j == 7) begin
                n_checks++;
                if (out[1:0] !== 2'b10) $display("FAIL phase_k7: out[1:0]=%b, required 10", out[1:0]);
                else n_pass++;
            end
            n_checks++;
            if ({out, sync, pending, wr_err} !== {m_out, m_sync, m_pend, m_err})
                $display("FAIL phase_offset: got %b, required %b", {out, sync, pending, wr_err}, {m_out, m_sync, m_pend, m_err});
            else n_pass++;
        end
    endtask

    task automatic test_atomic_commit();
        int k;
        write(0, 2, 1'b0);
        write(2, 7, 1'b0);
        wait_cnt(4);
        update = 1'b1; tick(); update = 1'b0;
        k = 0;
        while (!sync && k < 3 * P) begin
            tick(); k++;
            n_checks++;
            if ({out, sync, pending, wr_err} !== {m_out, m_sync, m_pend, m_err})
                $display("FAIL atomic: got %b, required %b", {out, sync, pending, wr_err}, {m_out, m_sync, m_pend, m_err});
            else n_pass++;
        end
        tick();
        n_checks++;
        if (out[0] !== 1'b1 || out[2] !== 1'b0) $display("FAIL atomic_k1: out=%b, required x0x1 (ch2 low, ch0 high)", out);
        else n_pass++;
    endtask

    task automatic test_reject();
        write(1, 10, 1'b0);
        n_checks++;
        if (wr_err !== 1'b1) $display("FAIL reject_data: wr_err=%b, required 1", wr_err);
        else n_pass++;
        tick();
        n_checks++;
        if (wr_err !== 1'b0) $display("FAIL reject_once: wr_err=%b, required 0", wr_err);
        else n_pass++;
        write(5, 2, 1'b0);
        n_checks++;
        if (wr_err !== 1'b1) $display("FAIL reject_addr: wr_err=%b, required 1", wr_err);
        else n_pass++;
        write(3, 9, 1'b0);
        n_checks++;
        if (wr_err !== 1'b0) $display("FAIL valid_no_err: wr_err=%b, required 0", wr_err);
        else n_pass++;
        update = 1'b1; tick(); update = 1'b0;
        for (int j = 0; j < 2 * P; j++) begin
            tick();
            n_checks++;
            if ({out, sync, pending, wr_err} !== {m_out, m_sync, m_pend, m_err})
                $display("FAIL reject_commit: got %b, required %b", {out, sync, pending, wr_err}, {m_out, m_sync, m_pend, m_err});
            else n_pass++;
        end
    endtask

    task automatic test_disable();
        write(3, 5, 1'b0);
        wait_cnt(3);
        update = 1'b1; tick(); update = 1'b0;
        wait_cnt(6);
        en = 1'b0;
        tick();
        n_checks++;
        if (out !== '0 || pending !== 1'b0 || sync !== 1'b0)
            $display("FAIL disable: out=%b pend=%b sync=%b, required 0 0 0", out, pending, sync);
        else n_pass++;
        tick();
        en = 1'b1;
        tick();
        n_checks++;
        if (sync !== 1'b1) $display("FAIL reenable_sync: sync=%b, required 1", sync);
        else n_pass++;
        for (int j = 0; j < 12; j++) begin
            tick();
            n_checks++;
            if ({out, sync, pending, wr_err} !== {m_out, m_sync, m_pend, m_err})
                $display("FAIL after_enable: got %b, required %b", {out, sync, pending, wr_err}, {m_out, m_sync, m_pend, m_err});
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        write(1, 4, 1'b0);
        update = 1'b1; tick(); update = 1'b0;
        n_checks++;
        if (pending !== 1'b1) $display("FAIL mid_reset_pre: pending=%b, required 1", pending);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (pending !== 1'b0 || out !== '0) $display("FAIL mid_reset: pend=%b out=%b, required 0 0000", pending, out);
        else n_pass++;
        rst = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick();
            n_checks++;
            if ((out !== 4'h0 && out !== 4'hF) || out !== m_out)
                $display("FAIL post_reset_phase0: out=%b, required %b (all equal)", out, m_out);
            else n_pass++;
        end
    endtask

`ifdef ARRAY_DUTY_EN
    task automatic test_duty();
        int k;
        int h2 = 0;
        write(0, 0, 1'b1);
        write(1, 10, 1'b1);
        write(2, 3, 1'b1);
        write(3, 11, 1'b1);
        n_checks++;
        if (wr_err !== 1'b1) $display("FAIL duty_reject: wr_err=%b, required 1", wr_err);
        else n_pass++;
        update = 1'b1; tick(); update = 1'b0;
        k = 0;
        while (!sync && k < 3 * P) begin tick(); k++; end
        for (int j = 0; j < P; j++) begin
            if (out[2]) h2++;
            n_checks++;
            if (out[0] !== 1'b0 || out[1] !== 1'b1) $display("FAIL duty_const: out=%b, required ch0 0 ch1 1", out);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (h2 != 3) $display("FAIL duty_ch2: highs=%0d, required 3", h2);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            en      = ($urandom_range(0, 19) != 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = A'($urandom_range(0, 5));
            wr_data = W'($urandom_range(0, 11));
`ifdef ARRAY_DUTY_EN
            wr_duty = $urandom_range(0, 1) == 1;
`endif
            update  = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if ({out, sync, pending, wr_err} !== {m_out, m_sync, m_pend, m_err})
                $display("FAIL random j=%0d: got %b, required %b", j, {out, sync, pending, wr_err}, {m_out, m_sync, m_pend, m_err});
            else n_pass++;
        end
        wr_en = 1'b0; update = 1'b0; wr_duty = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_phase_offset();
        test_atomic_commit();
        test_reject();
        test_disable();
        test_mid_reset();
`ifdef ARRAY_DUTY_EN
        test_duty();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
